// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the Fibonacci RV32 core.
// It walks one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
// It drives the imm_gen select and the ALU, register-file, PC and memory-request strobes.
// Strobes are decoded from the registered state and the instruction register.
// Three strobes also look at a live input: ir_we follows imem_ready, the branch pc_src
// follows alu_zero, and every strobe is forced low while rst is held.

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic [2:0]       imm_sel,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             dmem_req,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             timeout_err,
  output logic [RET_W-1:0] retired
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_branch, is_jal;
  logic       legal;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign is_r      = (opcode == OP_R_ALU);
  assign is_i      = (opcode == OP_I_ALU);
  assign is_load   = (opcode == OP_LOAD);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  // Only BEQ (000) and BNE (001) are implemented among the branches.
  assign legal     = is_r | is_i | is_load | is_jal | (is_branch & (funct3[2:1] == 2'b00));

  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Next-state, wait-counter, sticky-flag and retire-counter computation.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retired_d  = retired_q;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          state_d = DECODE;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end
      EXEC: begin
        if (is_r || is_i) begin
          state_d = WB;
        end else if (is_load) begin
          state_d = MEM;
        end else if (is_branch || is_jal) begin
          retired_d = retired_q + RET_W'(1);
          state_d   = FETCH;
        end else begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end
      MEM: begin
        if (dmem_ready) begin
          state_d = WB;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      WB: begin
        retired_d = retired_q + RET_W'(1);
        state_d   = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Controller state register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      retired_q  <= retired_d;
    end
  end

  // Per-state strobe decode; every strobe is low while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    imm_sel   = IMM_I;
    alu_src_b = 1'b0;
    alu_op    = 4'b0000;
    dmem_req  = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        EXEC: begin
          if (is_r) begin
            alu_op = {instr[30], funct3};
          end else if (is_i) begin
            alu_src_b = 1'b1;
            alu_op    = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
          end else if (is_load) begin
            alu_src_b = 1'b1;
          end else if (is_branch) begin
            imm_sel = IMM_B;
            alu_op  = 4'b1000;
            pc_we   = 1'b1;
            pc_src  = funct3[0] ? ~alu_zero : alu_zero;
          end else if (is_jal) begin
            imm_sel = IMM_J;
            reg_we  = 1'b1;
            wb_sel  = 2'b10;
            pc_we   = 1'b1;
            pc_src  = 1'b1;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
        end
        WB: begin
          reg_we = 1'b1;
          wb_sel = is_load ? 2'b01 : 2'b00;
          pc_we  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign illegal     = illegal_q;
  assign timeout_err = timeout_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl.
// The driver pushes one expected output snapshot per clock cycle into a queue.
// The snapshot comes from a per-instruction reference model.
// A separate monitor pops one snapshot at every falling edge and compares it with the DUT.
// The retired counter is built 4 bits wide so that a random run wraps it.

module tb_multicycle_ctrl;

   localparam int MEM_TO = 15;
   localparam int RW     = 4;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd4;

   typedef struct packed {
      logic          imemReq;
      logic          irWe;
      logic          pcWe;
      logic          pcSrc;
      logic [2:0]    immSel;
      logic          aluSrcB;
      logic [3:0]    aluOp;
      logic          dmemReq;
      logic          regWe;
      logic [1:0]    wbSel;
      logic          illegalF;
      logic          timeoutF;
      logic [RW-1:0] retiredV;
   } outs_t;

   logic          clk;
   logic          rst;
   logic [31:0]   instr;
   logic          alu_zero;
   logic          imem_ready;
   logic          dmem_ready;
   logic          imem_req;
   logic          ir_we;
   logic          pc_we;
   logic          pc_src;
   logic [2:0]    imm_sel;
   logic          alu_src_b;
   logic [3:0]    alu_op;
   logic          dmem_req;
   logic          reg_we;
   logic [1:0]    wb_sel;
   logic          illegal;
   logic          timeout_err;
   logic [RW-1:0] retired;

   outs_t expQ[$];
   string tagQ[$];

   int total = 0;
   int bad   = 0;

   int retM      = 0;
   bit illegalM  = 1'b0;
   bit timeoutM  = 1'b0;
   bit haltedM   = 1'b0;
   int budget    = -1;
   bit cut       = 1'b0;

   multicycle_ctrl #(.MEM_TIMEOUT(MEM_TO), .RET_W(RW)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .alu_zero    (alu_zero),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .imem_req    (imem_req),
      .ir_we       (ir_we),
      .pc_we       (pc_we),
      .pc_src      (pc_src),
      .imm_sel     (imm_sel),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .dmem_req    (dmem_req),
      .reg_we      (reg_we),
      .wb_sel      (wb_sel),
      .illegal     (illegal),
      .timeout_err (timeout_err),
      .retired     (retired)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Random single bit used for inputs the DUT has to ignore.
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Idle snapshot: no strobes, imm_sel at IMM_I, flags and retire count from the model.
   function automatic outs_t baseRec();
      outs_t r;
      r          = '0;
      r.immSel   = IMM_I;
      r.illegalF = illegalM;
      r.timeoutF = timeoutM;
      r.retiredV = RW'(retM);
      return r;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected during that cycle.
   task automatic applyStimulus(input outs_t exp, input string tag, input logic ir,
                                input logic dr, input logic az, input logic [31:0] ins);
      instr      = ins;
      imem_ready = ir;
      dmem_ready = dr;
      alu_zero   = az;
      expQ.push_back(exp);
      tagQ.push_back(tag);
      @(posedge clk);
      #1;
      if (budget > 0) begin
         budget = budget - 1;
         if (budget == 0) cut = 1'b1;
      end
   endtask

   // Compare the DUT outputs against one queued expectation.
   task automatic checkOutput(input string tag, input outs_t exp);
      outs_t act;
      act.imemReq  = imem_req;
      act.irWe     = ir_we;
      act.pcWe     = pc_we;
      act.pcSrc    = pc_src;
      act.immSel   = imm_sel;
      act.aluSrcB  = alu_src_b;
      act.aluOp    = alu_op;
      act.dmemReq  = dmem_req;
      act.regWe    = reg_we;
      act.wbSel    = wb_sel;
      act.illegalF = illegal;
      act.timeoutF = timeout_err;
      act.retiredV = retired;
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("[TB] FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   // Monitor: one expectation is consumed per falling edge while any are queued.
   initial begin
      outs_t e;
      string t;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, e);
         end
      end
   end

   // Hold reset for one cycle, expecting every output at its reset value.
   task automatic resetDut();
      outs_t r;
      rst      = 1'b1;
      retM     = 0;
      illegalM = 1'b0;
      timeoutM = 1'b0;
      haltedM  = 1'b0;
      cut      = 1'b0;
      budget   = -1;
      r        = baseRec();
      applyStimulus(r, "reset", rb(), rb(), rb(), $urandom);
      rst = 1'b0;
   endtask

   // Halted cycles: nothing may move whatever the inputs do.
   task automatic haltCycles(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(baseRec(), $sformatf("halt%0d", k), rb(), rb(), rb(), $urandom);
      end
   endtask

   // Reference model for one instruction. fw/mw are the not-ready cycles before
   // imem_ready/dmem_ready rise, and az is the ALU zero flag seen by a branch.
   task automatic runInstr(input logic [31:0] ins, input int fw, input int mw,
                           input logic az, input string nm);
      outs_t      r;
      logic [6:0] op;
      logic [2:0] f3;
      bit         isR, isI, isL, isB, isJ;
      op  = ins[6:0];
      f3  = ins[14:12];
      isR = (op == 7'b0110011);
      isI = (op == 7'b0010011);
      isL = (op == 7'b0000011);
      isB = (op == 7'b1100011);
      isJ = (op == 7'b1101111);

      for (int k = 0; k < fw; k++) begin
         r = baseRec();
         r.imemReq = 1'b1;
         applyStimulus(r, $sformatf("%s fetchwait%0d", nm, k), 1'b0, rb(), rb(), $urandom);
         if (cut) return;
         if (k == MEM_TO) begin
            timeoutM = 1'b1;
            haltedM  = 1'b1;
            return;
         end
      end
      r = baseRec();
      r.imemReq = 1'b1;
      r.irWe    = 1'b1;
      applyStimulus(r, $sformatf("%s fetch", nm), 1'b1, rb(), rb(), ins);
      if (cut) return;

      applyStimulus(baseRec(), $sformatf("%s decode", nm), rb(), rb(), rb(), ins);
      if (cut) return;
      if (!(isR || isI || isL || isJ || (isB && (f3 == 3'd0 || f3 == 3'd1)))) begin
         illegalM = 1'b1;
         haltedM  = 1'b1;
         return;
      end

      r = baseRec();
      if (isR) begin
         r.aluOp = {ins[30], f3};
      end else if (isI) begin
         r.aluSrcB = 1'b1;
         r.aluOp   = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
      end else if (isL) begin
         r.aluSrcB = 1'b1;
      end else if (isB) begin
         r.immSel = IMM_B;
         r.aluOp  = 4'b1000;
         r.pcWe   = 1'b1;
         r.pcSrc  = (f3 == 3'd0) ? az : !az;
      end else begin
         r.immSel = IMM_J;
         r.regWe  = 1'b1;
         r.wbSel  = 2'b10;
         r.pcWe   = 1'b1;
         r.pcSrc  = 1'b1;
      end
      applyStimulus(r, $sformatf("%s exec", nm), rb(), rb(), az, ins);
      if (cut) return;
      if (isB || isJ) begin
         retM = (retM + 1) % (1 << RW);
         return;
      end

      if (isL) begin
         for (int k = 0; k < mw; k++) begin
            r = baseRec();
            r.dmemReq = 1'b1;
            applyStimulus(r, $sformatf("%s memwait%0d", nm, k), rb(), 1'b0, rb(), ins);
            if (cut) return;
            if (k == MEM_TO) begin
               timeoutM = 1'b1;
               haltedM  = 1'b1;
               return;
            end
         end
         r = baseRec();
         r.dmemReq = 1'b1;
         applyStimulus(r, $sformatf("%s mem", nm), rb(), 1'b1, rb(), ins);
         if (cut) return;
      end

      r = baseRec();
      r.regWe = 1'b1;
      r.pcWe  = 1'b1;
      r.wbSel = isL ? 2'b01 : 2'b00;
      applyStimulus(r, $sformatf("%s wb", nm), rb(), rb(), rb(), ins);
      retM = (retM + 1) % (1 << RW);
   endtask

   // Random instruction drawn from all supported classes plus illegal encodings.
   function automatic logic [31:0] randInstr();
      logic [31:0] ins;
      logic [6:0]  badOps[6];
      int          pick;
      badOps = '{7'b0100011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1110011, 7'b0001111};
      ins  = $urandom;
      pick = $urandom_range(0, 9);
      case (pick)
         0, 1: ins[6:0] = 7'b0110011;
         2, 3: ins[6:0] = 7'b0010011;
         4, 5: ins[6:0] = 7'b0000011;
         6, 7: begin
            ins[6:0]   = 7'b1100011;
            ins[14:12] = 3'($urandom_range(0, 1));
         end
         8: ins[6:0] = 7'b1101111;
         default: begin
            if (rb()) begin
               ins[6:0]   = 7'b1100011;
               ins[14:12] = 3'($urandom_range(2, 7));
            end else begin
               ins[6:0] = badOps[$urandom_range(0, 5)];
            end
         end
      endcase
      return ins;
   endfunction

   function automatic int randWait();
      if ($urandom_range(0, 24) == 0) return $urandom_range(14, 17);
      return $urandom_range(0, 2);
   endfunction

   // Directed scenarios followed by a randomized instruction stream.
   initial begin
      rst        = 1'b1;
      instr      = '0;
      alu_zero   = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetDut();

      budget = 5;
      runInstr(32'h0040A103, 0, 10, 1'b0, "lw-abort");
      resetDut();

      runInstr(32'h00500093, 0, 0, 1'b0, "addi");
      runInstr(32'h00209463, 0, 0, 1'b0, "bne-taken");
      runInstr(32'h00209463, 0, 0, 1'b1, "bne-nottaken");
      runInstr(32'h00208463, 1, 0, 1'b1, "beq-taken");
      runInstr(32'h008000EF, 0, 0, 1'b0, "jal");
      runInstr(32'h40C5D533, 0, 0, 1'b0, "sra");
      runInstr(32'h4055D513, 2, 0, 1'b0, "srai");
      runInstr(32'h0040A103, 0, 15, 1'b0, "lw-wait15");
      runInstr(32'h0040A103, 0, 16, 1'b0, "lw-wait16");
      haltCycles(4);
      resetDut();

      runInstr(32'h0020A023, 0, 0, 1'b0, "sw");
      haltCycles(5);
      resetDut();

      runInstr(32'h00500093, 16, 0, 1'b0, "fetch-wait16");
      haltCycles(3);
      resetDut();
      runInstr(32'h00500093, 15, 0, 1'b0, "fetch-wait15");

      for (int i = 0; i < 250; i++) begin
         runInstr(randInstr(), randWait(), randWait(), rb(), $sformatf("rnd%0d", i));
         if (haltedM) begin
            haltCycles(3);
            resetDut();
         end
      end

      @(negedge clk);
      total = total + 1;
      if (expQ.size() != 0) begin
         bad = bad + 1;
         $display("[TB] FAIL drain got=%0d want=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
